fetch_sequencer: RTL and testbench

- Controls instruction fetch between the IFU (PC register and next-PC mux) and a variable-latency instruction memory with request/grant/response handshakes.
- Issues one fetch at a time and holds the returned word in a 1-entry buffer until decode accepts it.
- Drives the IFU `En` only when decode consumes an instruction or a redirect occurs.
- Kills wrong-path fetches on branch, jump, exception entry (`req`) and `eret`.

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer_watchdog.sv | 47 ++++
 rtl/fetch_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_pkg : fetch FSM state encodings, NOP word, buffer slot type
// Rev 1.0
// ============================================================================
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_ISSUE = 3'd1,
      FS_WAIT  = 3'd2,
      FS_DROP  = 3'd3,
      FS_HOLD  = 3'd4
   } fs_state_e;

   localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic        adel;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_buf_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_watchdog : response timer, active only with FETCH_TIMEOUT_EN
// Rev 1.0
// ============================================================================
module fetch_sequencer_watchdog #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic run_i,
   output logic expired_o
);

`ifdef FETCH_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] count_q, count_d;

   assign expired_o = run_i & (count_q == LIMIT);

   always_comb begin
      count_d = count_q;
      if (start_i) begin
         count_d = '0;
      end else if (run_i && !expired_o) begin
         count_d = count_q + TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
`else
   logic unused_wd;
   assign unused_wd = clk ^ reset ^ start_i ^ run_i ^ ((TIMEOUT_CYCLES > 0) ^ (TIMEOUT_W > 0));
   assign expired_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : single-outstanding fetch controller with 1-entry decode
// buffer; FETCH_TIMEOUT_EN adds a response watchdog.            Rev 1.0
// ============================================================================
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_i,
   input  logic        adel_i,
   input  logic        redirect_i,
   input  logic        exc_req_i,
   input  logic        id_ready_i,
   output logic        pc_en_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic        if_adel_o
);

   fs_state_e   state_q, state_d;
   logic        kill_q, kill_d;
   logic        fresh_q, fresh_d;
   logic [31:0] addr_q, addr_d;
   fetch_buf_t  buf_q, buf_d;

   logic        flush, consume, rvalid, timeout, wd_expired;
   logic [31:0] cur_addr;

   assign flush      = redirect_i | exc_req_i;
   assign if_valid_o = (state_q == FS_HOLD) & buf_q.valid & ~flush;
   assign consume    = if_valid_o & id_ready_i;
   assign pc_en_o    = consume | redirect_i;

   // The IFU only settles the new PC on the first ISSUE cycle, so that cycle
   // presents pc_i directly and later cycles replay the captured copy.
   assign cur_addr    = fresh_q ? pc_i : addr_q;
   assign imem_req_o  = (state_q == FS_ISSUE) & ~(fresh_q & adel_i);
   assign imem_addr_o = imem_req_o ? cur_addr : '0;

   assign if_instr_o = buf_q.instr;
   assign if_pc_o    = buf_q.pc;
   assign if_adel_o  = buf_q.adel;

   fetch_sequencer_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_W      (TIMEOUT_W)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .start_i   (imem_req_o & imem_gnt_i),
      .run_i     ((state_q == FS_WAIT) | (state_q == FS_DROP)),
      .expired_o (wd_expired)
   );

`ifdef FETCH_TIMEOUT_EN
   logic stale_q, stale_d;

   // A response that arrives after its fetch timed out is swallowed here.
   assign rvalid  = imem_rvalid_i & ~stale_q;
   assign timeout = wd_expired & ~rvalid;

   always_comb begin
      stale_d = timeout | (stale_q & ~imem_rvalid_i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stale_q <= 1'b0;
      end else begin
         stale_q <= stale_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = wd_expired;
   assign rvalid         = imem_rvalid_i;
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      fresh_d = 1'b0;
      addr_d  = addr_q;
      buf_d   = buf_q;
      case (state_q)
         FS_IDLE: begin
            state_d = FS_ISSUE;
            fresh_d = 1'b1;
         end
         FS_ISSUE: begin
            if (fresh_q && adel_i) begin
               if (flush) begin
                  fresh_d = 1'b1;
               end else begin
                  buf_d.valid = 1'b1;
                  buf_d.adel  = 1'b1;
                  buf_d.pc    = pc_i;
                  buf_d.instr = FETCH_NOP;
                  state_d     = FS_HOLD;
               end
            end else begin
               addr_d = cur_addr;
               kill_d = kill_q | flush;
               if (imem_gnt_i) begin
                  state_d = (kill_q | flush) ? FS_DROP : FS_WAIT;
                  kill_d  = 1'b0;
               end
            end
         end
         FS_WAIT: begin
            if (rvalid || timeout) begin
               if (flush) begin
                  state_d = FS_ISSUE;
                  fresh_d = 1'b1;
               end else begin
                  buf_d.valid = 1'b1;
                  buf_d.adel  = ~rvalid;
                  buf_d.pc    = addr_q;
                  buf_d.instr = rvalid ? imem_rdata_i : FETCH_NOP;
                  state_d     = FS_HOLD;
               end
            end else if (flush) begin
               state_d = FS_DROP;
            end
         end
         FS_DROP: begin
            // A killed fetch that times out is abandoned, never delivered.
            if (rvalid || timeout) begin
               state_d = FS_ISSUE;
               fresh_d = 1'b1;
            end
         end
         FS_HOLD: begin
            if (flush || consume) begin
               buf_d.valid = 1'b0;
               state_d     = FS_ISSUE;
               fresh_d     = 1'b1;
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FS_IDLE;
         kill_q  <= 1'b0;
         fresh_q <= 1'b0;
         addr_q  <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
         fresh_q <= fresh_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : scoreboard bench with IFU PC model and memory model
// Rev 1.0
// ============================================================================
module tb_fetch_sequencer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc = '0;
   logic        adel = 1'b0;
   logic        redirect = 1'b0;
   logic        exc_req = 1'b0;
   logic        id_ready = 1'b0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;

   logic        pc_en_o, imem_req_o, if_valid_o, if_adel_o;
   logic [31:0] imem_addr_o, if_instr_o, if_pc_o;

   logic [31:0] target = '0;
   logic        mem_busy = 1'b0;
   logic [31:0] mem_addr = '0;
   int          rsp_cnt = 0;
   int          req_age = 0;
   int          gnt_delay = 0;
   int          rsp_delay = 0;

   logic        s_req, s_pc_en, s_if_valid, s_adel;
   logic [31:0] s_addr, s_instr, s_pc;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .TIMEOUT_CYCLES (255),
      .TIMEOUT_W      (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_i          (pc),
      .adel_i        (adel),
      .redirect_i    (redirect),
      .exc_req_i     (exc_req),
      .id_ready_i    (id_ready),
      .pc_en_o       (pc_en_o),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .if_valid_o    (if_valid_o),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_adel_o     (if_adel_o)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"},   {28'b0, pc_en_o, imem_req_o, if_valid_o, if_adel_o}, 32'h0);
      check({tag, "_addr"},  imem_addr_o, 32'h0);
      check({tag, "_instr"}, if_instr_o, 32'h0);
      check({tag, "_pc"},    if_pc_o, 32'h0);
   endtask

   // One clock cycle: memory answers, outputs are sampled, the scoreboard
   // consumes deliveries, then the IFU PC and memory state advance.
   task automatic cycle();
      logic [31:0] npc;
      exp_t        e;
      #1;
      gnt    = 1'b0;
      rvalid = 1'b0;
      rdata  = '0;
      if (mem_busy && rsp_cnt == 0) begin
         rvalid = 1'b1;
         rdata  = word(mem_addr);
      end
      if (imem_req_o && !mem_busy && req_age >= gnt_delay) gnt = 1'b1;
      #1;
      s_req      = imem_req_o;
      s_addr     = imem_addr_o;
      s_pc_en    = pc_en_o;
      s_if_valid = if_valid_o;
      s_instr    = if_instr_o;
      s_pc       = if_pc_o;
      s_adel     = if_adel_o;
      if (s_if_valid && id_ready) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("sb_pc", s_pc, e.pc);
            check("sb_instr", s_instr, e.instr);
            check("sb_adel", 32'(s_adel), 32'(e.adel));
         end
      end
      if (exc_req)      npc = 32'h4180;
      else if (s_pc_en) npc = redirect ? target : pc + 32'd4;
      else              npc = pc;
      @(posedge clk);
      #1;
      pc = npc;
      if (rvalid) mem_busy = 1'b0;
      else if (mem_busy) rsp_cnt--;
      if (gnt) begin
         mem_busy = 1'b1;
         rsp_cnt  = rsp_delay;
         mem_addr = s_addr;
         req_age  = 0;
      end else if (s_req) begin
         req_age++;
      end else begin
         req_age = 0;
      end
      gnt    = 1'b0;
      rvalid = 1'b0;
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      reset     = 1'b0;
      redirect  = 1'b0;
      exc_req   = 1'b0;
      adel      = 1'b0;
      id_ready  = 1'b1;
      target    = '0;
      pc        = start_pc;
      mem_busy  = 1'b0;
      rsp_cnt   = 0;
      req_age   = 0;
      gnt_delay = 0;
      rsp_delay = 0;
      gnt       = 1'b0;
      rvalid    = 1'b0;
      rdata     = '0;
      #1;
      check_reset_outputs("rst");
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      // Back-to-back fetches with zero-wait memory.
      do_reset(32'h3000);
      sb.push_back('{32'h3000, word(32'h3000), 1'b0});
      sb.push_back('{32'h3004, word(32'h3004), 1'b0});
      sb.push_back('{32'h3008, word(32'h3008), 1'b0});
      for (int c = 0; c < 10; c++) begin
         cycle();
         check("t1_req", 32'(s_req), 32'(c == 1 || c == 4 || c == 7));
         if (s_req) check("t1_addr", s_addr, 32'h3000 + 32'((c - 1) / 3 * 4));
         check("t1_pc_en", 32'(s_pc_en), 32'(c == 3 || c == 6 || c == 9));
      end
      check("t1_sb_left", 32'(sb.size()), 32'd0);

      // Slow grant with a redirect while the request is pending.
      do_reset(32'h3000);
      target    = 32'h3040;
      gnt_delay = 3;
      sb.push_back('{32'h3040, word(32'h3040), 1'b0});
      for (int c = 0; c < 9; c++) begin
         redirect = (c == 2);
         if (c == 5) gnt_delay = 0;
         cycle();
         check("t2_req", 32'(s_req), 32'((c >= 1 && c <= 4) || c == 6));
         if (c >= 1 && c <= 4) check("t2_addr_hold", s_addr, 32'h3000);
         if (c == 6) check("t2_addr_redir", s_addr, 32'h3040);
         check("t2_pc_en", 32'(s_pc_en), 32'(c == 2 || c == 8));
         check("t2_valid", 32'(s_if_valid), 32'(c == 8));
      end
      redirect = 1'b0;
      check("t2_sb_left", 32'(sb.size()), 32'd0);

      // Decode stall for five cycles in HOLD.
      do_reset(32'h3000);
      sb.push_back('{32'h3000, word(32'h3000), 1'b0});
      for (int c = 0; c < 10; c++) begin
         id_ready = (c >= 8);
         cycle();
         check("t3_valid", 32'(s_if_valid), 32'(c >= 3 && c <= 8));
         check("t3_pc_en", 32'(s_pc_en), 32'(c == 8));
         if (c >= 3 && c <= 8) check("t3_instr", s_instr, word(32'h3000));
         if (c == 9) begin
            check("t3_req", 32'(s_req), 32'd1);
            check("t3_addr", s_addr, 32'h3004);
         end
      end
      check("t3_sb_left", 32'(sb.size()), 32'd0);

      // Response and exception entry in the same cycle.
      do_reset(32'h3000);
      sb.push_back('{32'h4180, word(32'h4180), 1'b0});
      for (int c = 0; c < 6; c++) begin
         exc_req = (c == 2);
         cycle();
         check("t4_pc_en", 32'(s_pc_en), 32'(c == 5));
         check("t4_valid", 32'(s_if_valid), 32'(c == 5));
         if (c == 3) begin
            check("t4_req", 32'(s_req), 32'd1);
            check("t4_addr", s_addr, 32'h4180);
         end
      end
      exc_req = 1'b0;
      check("t4_sb_left", 32'(sb.size()), 32'd0);

      // Address error: no memory request, NOP slot flagged.
      do_reset(32'h3002);
      adel = 1'b1;
      sb.push_back('{32'h3002, 32'h0, 1'b1});
      for (int c = 0; c < 4; c++) begin
         id_ready = (c >= 3);
         cycle();
         check("t5_req", 32'(s_req), 32'd0);
         check("t5_valid", 32'(s_if_valid), 32'(c >= 2));
         check("t5_pc_en", 32'(s_pc_en), 32'(c == 3));
         if (c == 2) begin
            check("t5_instr", s_instr, 32'h0);
            check("t5_adel", 32'(s_adel), 32'd1);
            check("t5_pc", s_pc, 32'h3002);
         end
      end
      adel = 1'b0;
      check("t5_sb_left", 32'(sb.size()), 32'd0);

      // Reset while waiting; the stale response lands after release.
      do_reset(32'h3000);
      rsp_delay = 3;
      sb.push_back('{32'h3100, word(32'h3100), 1'b0});
      for (int c = 0; c < 9; c++) begin
         if (c == 2) rsp_delay = 0;
         if (c == 3) begin
            reset = 1'b0;
            pc    = 32'h3100;
         end
         if (c == 3 || c == 4) begin
            #1;
            check_reset_outputs("t6_rst");
         end
         if (c == 5) reset = 1'b1;
         cycle();
         check("t6_req", 32'(s_req), 32'(c == 1 || c == 6));
         if (c == 6) check("t6_addr", s_addr, 32'h3100);
         check("t6_valid", 32'(s_if_valid), 32'(c == 8));
         check("t6_pc_en", 32'(s_pc_en), 32'(c == 8));
      end
      check("t6_sb_left", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
